nurn_status_sequencer: RTL and testbench

//  Per-time-step neuron update controller driving status-memory read port A / write port B.
//  On start_i, sweeps neurons 0..NUM_NURNS-1: reads Bias, MembPot, Th, PostSpikeHist;

---
 rtl/nurn_pkg.sv | 22 ++
 rtl/sat_add3.sv | 28 ++
 rtl/nurn_status_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nurn_status_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nurn_pkg.sv
// Shared definitions for the neuron status sequencer:
// status-word select codes and the sweep FSM state encoding.
package nurn_pkg;

   localparam logic [1:0] SEL_BIAS = 2'b00;
   localparam logic [1:0] SEL_VM   = 2'b01;
   localparam logic [1:0] SEL_TH   = 2'b10;
   localparam logic [1:0] SEL_HIST = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_B,
      ST_RD_V,
      ST_RD_T,
      ST_RD_H,
      ST_CALC,
      ST_WR_V,
      ST_WR_H,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sat_add3.sv
// Three-operand signed adder, clamped to the W-bit signed range.
// Two guard bits hold any sum of three W-bit operands exactly.
module sat_add3 #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   output logic signed [W-1:0] y
);

   logic signed [W+1:0] sum;

   // Exact sum, then clamp when the top three bits disagree
   always_comb begin
      sum = {{2{a[W-1]}}, a}
          + {{2{b[W-1]}}, b}
          + {{2{c[W-1]}}, c};
      if (sum[W+1:W-1] == 3'b000 || sum[W+1:W-1] == 3'b111) begin
         y = sum[W-1:0];
      end else if (sum[W+1]) begin
         y = {1'b1, {(W-1){1'b0}}};
      end else begin
         y = {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/nurn_status_sequencer.sv
// Per-time-step neuron sweep: reads bias/V/Th/history for each neuron,
// integrates with the synaptic sum, fires on threshold, writes back.
module nurn_status_sequencer
   import nurn_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int DSIZE              = 16,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int STDP_WIN_BIT_WIDTH = 8,
   parameter logic [DSIZE-1:0] RESET_POT = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          start_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatRd_A_o,
   output logic                          rdEn_StatRd_A_o,
   input  logic [DSIZE-1:0]              data_StatRd_A_i,
   output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatWr_B_o,
   output logic                          wrEn_StatWr_B_o,
   output logic [DSIZE-1:0]              data_StatWr_B_o,
   output logic                          syn_rdEn_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] syn_nurn_o,
   input  logic [DSIZE-1:0]              syn_data_i,
   output logic                          spike_vld_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] spike_nurn_o
);

   localparam int CW = NURN_CNT_BIT_WIDTH;
   localparam int HW = STDP_WIN_BIT_WIDTH;
   localparam logic [CW-1:0] LAST_NURN = CW'(NUM_NURNS - 1);

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q;

   logic signed [DSIZE-1:0] bias_q, syn_q, vm_q, th_q;
   logic signed [DSIZE-1:0] vsum, vnew_q;
   logic [HW-2:0] hist_q;
   logic spike_q, fire;

   sat_add3 #(.W(DSIZE)) u_sat (
      .a (vm_q),
      .b (bias_q),
      .c (syn_q),
      .y (vsum)
   );

   assign fire = (vsum >= th_q);

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Neuron index: advances after each history write, wraps at the last neuron
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (state_q == ST_WR_H) begin
         cnt_q <= (cnt_q == LAST_NURN) ? '0 : cnt_q + 1'b1;
      end else if (state_q == ST_DONE) begin
         cnt_q <= '0;
      end
   end

   // Capture read data one cycle after each read, then register the update
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bias_q  <= '0;
         syn_q   <= '0;
         vm_q    <= '0;
         th_q    <= '0;
         hist_q  <= '0;
         vnew_q  <= '0;
         spike_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RD_V: begin
               bias_q <= data_StatRd_A_i;
               syn_q  <= syn_data_i;
            end
            ST_RD_T: vm_q <= data_StatRd_A_i;
            ST_RD_H: th_q <= data_StatRd_A_i;
            ST_CALC: begin
               hist_q  <= data_StatRd_A_i[HW-2:0];
               spike_q <= fire;
               vnew_q  <= fire ? RESET_POT : vsum;
            end
            default: ;
         endcase
      end
   end

   // Next-state and port drive; all ports idle unless the state uses them
   always_comb begin
      state_d         = state_q;
      busy_o          = (state_q != ST_IDLE);
      done_o          = 1'b0;
      Addr_StatRd_A_o = '0;
      rdEn_StatRd_A_o = 1'b0;
      Addr_StatWr_B_o = '0;
      wrEn_StatWr_B_o = 1'b0;
      data_StatWr_B_o = '0;
      syn_rdEn_o      = 1'b0;
      syn_nurn_o      = '0;
      spike_vld_o     = 1'b0;
      spike_nurn_o    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RD_B;
         end
         ST_RD_B: begin
            rdEn_StatRd_A_o = 1'b1;
            Addr_StatRd_A_o = {cnt_q, SEL_BIAS};
            syn_rdEn_o      = 1'b1;
            syn_nurn_o      = cnt_q;
            state_d         = ST_RD_V;
         end
         ST_RD_V: begin
            rdEn_StatRd_A_o = 1'b1;
            Addr_StatRd_A_o = {cnt_q, SEL_VM};
            state_d         = ST_RD_T;
         end
         ST_RD_T: begin
            rdEn_StatRd_A_o = 1'b1;
            Addr_StatRd_A_o = {cnt_q, SEL_TH};
            state_d         = ST_RD_H;
         end
         ST_RD_H: begin
            rdEn_StatRd_A_o = 1'b1;
            Addr_StatRd_A_o = {cnt_q, SEL_HIST};
            state_d         = ST_CALC;
         end
         ST_CALC: begin
            state_d = ST_WR_V;
         end
         ST_WR_V: begin
            wrEn_StatWr_B_o = 1'b1;
            Addr_StatWr_B_o = {cnt_q, SEL_VM};
            data_StatWr_B_o = vnew_q;
            spike_vld_o     = spike_q;
            spike_nurn_o    = spike_q ? cnt_q : '0;
            state_d         = ST_WR_H;
         end
         ST_WR_H: begin
            wrEn_StatWr_B_o = 1'b1;
            Addr_StatWr_B_o = {cnt_q, SEL_HIST};
            data_StatWr_B_o = {{(DSIZE-HW){1'b0}}, hist_q, spike_q};
            state_d = (cnt_q == LAST_NURN) ? ST_DONE : ST_RD_B;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_nurn_status_sequencer.sv
// Bench for nurn_status_sequencer: status memory and synaptic-sum models,
// table vectors, timing/corner sequences and randomized sweeps vs a model.
module tb_nurn_status_sequencer;

   localparam int N  = 4;
   localparam int DS = 16;
   localparam int CW = 2;
   localparam int AW = CW + 2;
   localparam int TO = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic busy, done, rd_en, wr_en, syn_rd, spk_vld;
   logic [AW-1:0] addr_a, addr_b;
   logic [DS-1:0] rdata, wdata, sdata;
   logic [CW-1:0] syn_nurn, spk_nurn;

   logic [DS-1:0] img [16];
   logic [DS-1:0] mem [16];
   logic [DS-1:0] syn_tab [N];
   logic ld = 1'b0;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int both_cnt = 0;
   int rdb_q[$];
   int spk_q[$];

   always #5 clk = ~clk;

   nurn_status_sequencer #(
      .NUM_NURNS          (N),
      .DSIZE              (DS),
      .NURN_CNT_BIT_WIDTH (CW),
      .STDP_WIN_BIT_WIDTH (8),
      .RESET_POT          (16'h0000)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_i         (start),
      .busy_o          (busy),
      .done_o          (done),
      .Addr_StatRd_A_o (addr_a),
      .rdEn_StatRd_A_o (rd_en),
      .data_StatRd_A_i (rdata),
      .Addr_StatWr_B_o (addr_b),
      .wrEn_StatWr_B_o (wr_en),
      .data_StatWr_B_o (wdata),
      .syn_rdEn_o      (syn_rd),
      .syn_nurn_o      (syn_nurn),
      .syn_data_i      (sdata),
      .spike_vld_o     (spk_vld),
      .spike_nurn_o    (spk_nurn)
   );

   // Status memory (1-cycle read) and synaptic-sum source
   always @(posedge clk) begin
      if (ld) mem <= img;
      else if (wr_en) mem[addr_b] <= wdata;
      if (rd_en) rdata <= mem[addr_a];
      if (syn_rd) sdata <= syn_tab[syn_nurn];
   end

   // Event log sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) wr_cnt++;
      if (done) done_cnt++;
      if (rd_en && wr_en) both_cnt++;
      if (rd_en && addr_a[1:0] == 2'b00) rdb_q.push_back(int'(addr_a[3:2]));
      if (spk_vld) spk_q.push_back(int'(spk_nurn));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference neuron update from the arithmetic rules
   function automatic void model(input logic [15:0] b, v, th, s, h,
                                 output logic [15:0] nv,
                                 output logic [15:0] nh,
                                 output bit sp);
      int sum;
      sum = int'($signed(v)) + int'($signed(b)) + int'($signed(s));
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      sp = (sum >= int'($signed(th)));
      nv = sp ? 16'h0000 : sum[15:0];
      nh = 16'((((int'(h) & 255) * 2) + (sp ? 1 : 0)) % 256);
   endfunction

   typedef struct {
      logic [15:0] b, v, th, s, h, ev, eh;
      bit esp;
   } vec_t;

   task automatic load_img();
      @(negedge clk); ld = 1'b1;
      @(negedge clk); ld = 1'b0;
   endtask

   task automatic run_sweep(input int restart_at, output int n,
                            output int busy_n);
      rdb_q.delete();
      spk_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 1;
      busy_n = 0;
      while (!done && n < TO) begin
         if (busy) busy_n++;
         @(negedge clk);
         n++;
         start = (n == restart_at);
      end
      start = 1'b0;
      if (n >= TO) chk("sweep_timeout", 64'(n), 64'(29));
      @(negedge clk);
   endtask

   task automatic verify(input string tag);
      logic [15:0] ev, eh;
      bit sp;
      int exp_spk[$];
      for (int k = 0; k < N; k++) begin
         model(img[k*4], img[k*4+1], img[k*4+2], syn_tab[k], img[k*4+3],
               ev, eh, sp);
         chk($sformatf("%s_v%0d", tag, k), 64'(mem[k*4+1]), 64'(ev));
         chk($sformatf("%s_h%0d", tag, k), 64'(mem[k*4+3]), 64'(eh));
         if (sp) exp_spk.push_back(k);
      end
      chk($sformatf("%s_nspk", tag), 64'(spk_q.size()), 64'(exp_spk.size()));
      for (int i = 0; i < exp_spk.size() && i < spk_q.size(); i++)
         chk($sformatf("%s_spk%0d", tag, i), 64'(spk_q[i]), 64'(exp_spk[i]));
   endtask

   initial begin
      vec_t vt[4];
      int n, bn, d0, w0;
      bit seen;

      #2 rst_n = 1'b0;
      #10;
      chk("reset_outputs",
          64'({busy, done, rd_en, wr_en, syn_rd, spk_vld,
               addr_a, addr_b, wdata, syn_nurn, spk_nurn}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors: one per neuron in a single sweep
      vt[0] = '{16'h0010, 16'h01F0, 16'h0200, 16'h0000, 16'h0003,
                16'h0000, 16'h0007, 1'b1};
      vt[1] = '{16'h0010, 16'h0100, 16'h0200, 16'h0005, 16'h0003,
                16'h0115, 16'h0006, 1'b0};
      vt[2] = '{16'h0020, 16'h7FF0, 16'h7FFF, 16'h0010, 16'h0000,
                16'h0000, 16'h0001, 1'b1};
      vt[3] = '{16'h0000, 16'h8010, 16'h0200, 16'hFFC0, 16'h0080,
                16'h8000, 16'h0000, 1'b0};
      for (int i = 0; i < N; i++) begin
         img[i*4]   = vt[i].b;
         img[i*4+1] = vt[i].v;
         img[i*4+2] = vt[i].th;
         img[i*4+3] = vt[i].h;
         syn_tab[i] = vt[i].s;
      end
      load_img();
      run_sweep(0, n, bn);
      for (int i = 0; i < N; i++) begin
         seen = 1'b0;
         foreach (spk_q[j]) if (spk_q[j] == i) seen = 1'b1;
         chk($sformatf("vec%0d_v", i), 64'(mem[i*4+1]), 64'(vt[i].ev));
         chk($sformatf("vec%0d_h", i), 64'(mem[i*4+3]), 64'(vt[i].eh));
         chk($sformatf("vec%0d_spk", i), 64'(seen), 64'(vt[i].esp));
      end
      verify("tab");

      // Sweep timing and neuron order
      load_img();
      run_sweep(0, n, bn);
      chk("done_cycle", 64'(n), 64'(29));
      chk("busy_cycles", 64'(bn), 64'(28));
      chk("idle_after", 64'({busy, done}), 64'(0));
      chk("order_len", 64'(rdb_q.size()), 64'(N));
      for (int i = 0; i < N && i < rdb_q.size(); i++)
         chk($sformatf("order%0d", i), 64'(rdb_q[i]), 64'(i));

      // start_i during a sweep is ignored
      load_img();
      d0 = done_cnt;
      w0 = wr_cnt;
      run_sweep(10, n, bn);
      repeat (40) @(negedge clk);
      chk("restart_done_cnt", 64'(done_cnt - d0), 64'(1));
      chk("restart_wr_cnt", 64'(wr_cnt - w0), 64'(2 * N));
      verify("restart");

      // Reset mid-sweep at neuron 2, RD_T
      load_img();
      w0 = wr_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (16) @(negedge clk);
      chk("mid_addr", 64'({rd_en, addr_a}), 64'({1'b1, 2'd2, 2'b10}));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs",
          64'({busy, done, rd_en, wr_en, syn_rd, spk_vld,
               addr_a, addr_b, wdata, syn_nurn, spk_nurn}), 64'(0));
      chk("mid_rst_wr_cnt", 64'(wr_cnt - w0), 64'(4));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_wr_cnt", 64'(wr_cnt - w0), 64'(4));
      chk("post_rst_v2", 64'(mem[9]), 64'(img[9]));
      load_img();
      run_sweep(0, n, bn);
      chk("post_rst_first", 64'(rdb_q.size() > 0 ? rdb_q[0] : -1), 64'(0));
      chk("post_rst_done", 64'(n), 64'(29));
      verify("post_rst");

      // Randomized sweeps
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
         for (int i = 0; i < N; i++) syn_tab[i] = 16'($urandom);
         if (r % 2 == 1)
            for (int i = 0; i < N; i++) img[i*4+2] = 16'($urandom_range(0, 1023));
         load_img();
         run_sweep(0, n, bn);
         verify($sformatf("rnd%0d", r));
      end

      chk("port_exclusive", 64'(both_cnt), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
